// File: rtl/pam_ctrl_pkg.sv
// Shared definitions for the pamPy fetch control path: FSM states,
// PC source select codes and PC step select codes.
package pam_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WAIT_I,
        S_INSTR,
        S_WAIT_A,
        S_ARG,
        S_WAIT_E,
        S_EXT,
        S_ISSUE,
        S_HALT
    } state_e;

    // SEL_MUX: PC source
    localparam logic [1:0] PC_STEP   = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_REL    = 2'b10;
    localparam logic [1:0] PC_FSTACK = 2'b11;

    // SEL_PC_UPDATER: step size after a byte fetch vs. after an extension word
    localparam logic UPD_BYTE = 1'b0;
    localparam logic UPD_WORD = 1'b1;

    // MEM_LATENCY tops out at 4, so the wait counter only ever holds 0..3
    localparam int WAIT_W = 2;

    function automatic logic is_wait(state_e s);
        return (s == S_WAIT_I) || (s == S_WAIT_A) || (s == S_WAIT_E);
    endfunction

endpackage

// File: rtl/latency_timer.sv
// Loadable down-counter covering the instruction-memory latency; done is
// high once the count has reached zero.
module latency_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control FSM: walks instruction / argument / extension fetches,
// issues to execute over valid/ready and redirects the PC on branches.
module fetch_sequencer
    import pam_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 dec_has_arg,
    input  logic                 dec_is_jump,
    input  logic                 exec_ready,
    input  logic                 branch_req,
    input  logic [1:0]           branch_type,
    input  logic                 halt_req,
    output logic                 CTRL_REG_INSTR,
    output logic                 CTRL_REG_ARG,
    output logic                 CTRL_REG_JUMP,
    output logic                 CTRL_REG_PC,
    output logic                 SEL_PC_UPDATER,
    output logic [1:0]           SEL_MUX,
    output logic                 instr_valid,
    output logic                 busy,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] issue_count
);

    state_e state, state_nx;
    logic   wait_done;
    logic   hs;

    // Counter is loaded only on entry to a wait state, so every wait lasts
    // exactly MEM_LATENCY cycles.
    latency_timer #(.W(WAIT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (is_wait(state_nx) && !is_wait(state)),
        .load_val (WAIT_W'(MEM_LATENCY - 1)),
        .en       (is_wait(state)),
        .done     (wait_done)
    );

    assign hs = (state == S_ISSUE) && exec_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            issue_count <= '0;
        end else begin
            state <= state_nx;
            if (hs)
                issue_count <= issue_count + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_nx       = state;
        CTRL_REG_INSTR = 1'b0;
        CTRL_REG_ARG   = 1'b0;
        CTRL_REG_JUMP  = 1'b0;
        CTRL_REG_PC    = 1'b0;
        SEL_PC_UPDATER = UPD_BYTE;
        SEL_MUX        = PC_STEP;
        instr_valid    = 1'b0;
        busy           = (state != S_IDLE) && (state != S_HALT);
        halted         = (state == S_HALT);
        case (state)
            S_IDLE:   if (start) state_nx = S_WAIT_I;
            S_WAIT_I: if (wait_done) state_nx = S_INSTR;
            S_INSTR: begin
                CTRL_REG_INSTR = 1'b1;
                CTRL_REG_PC    = 1'b1;
                state_nx       = S_WAIT_A;
            end
            S_WAIT_A: if (wait_done) state_nx = dec_has_arg ? S_ARG : S_ISSUE;
            S_ARG: begin
                CTRL_REG_ARG = 1'b1;
                CTRL_REG_PC  = 1'b1;
                state_nx     = dec_is_jump ? S_WAIT_E : S_ISSUE;
            end
            S_WAIT_E: if (wait_done) state_nx = S_EXT;
            S_EXT: begin
                CTRL_REG_JUMP  = 1'b1;
                CTRL_REG_PC    = 1'b1;
                SEL_PC_UPDATER = UPD_WORD;
                state_nx       = S_ISSUE;
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                if (hs) begin
                    if (halt_req) begin
                        state_nx = S_HALT;
                    end else begin
                        // branch_type 00 falls through to a sequential fetch
                        if (branch_req && branch_type != PC_STEP) begin
                            CTRL_REG_PC = 1'b1;
                            SEL_MUX     = branch_type;
                        end
                        state_nx = S_WAIT_I;
                    end
                end
            end
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: one instance at MEM_LATENCY=1 with a
// 4-bit issue counter, one at MEM_LATENCY=3 with the default counter.
module tb_fetch_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0, dec_has_arg = 1'b0, dec_is_jump = 1'b0;
    logic       exec_ready = 1'b0, branch_req = 1'b0, halt_req = 1'b0;
    logic [1:0] branch_type = 2'b00;

    logic       a_instr, a_arg, a_jump, a_pc, a_upd, a_valid, a_busy, a_halted;
    logic [1:0] a_mux;
    logic [3:0] a_cnt;
    logic       b_instr, b_arg, b_jump, b_pc, b_upd, b_valid, b_busy, b_halted;
    logic [1:0] b_mux;
    logic [15:0] b_cnt;

    int vec = 0;
    int miscmp = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.MEM_LATENCY(1), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .dec_has_arg(dec_has_arg),
        .dec_is_jump(dec_is_jump), .exec_ready(exec_ready), .branch_req(branch_req),
        .branch_type(branch_type), .halt_req(halt_req),
        .CTRL_REG_INSTR(a_instr), .CTRL_REG_ARG(a_arg), .CTRL_REG_JUMP(a_jump),
        .CTRL_REG_PC(a_pc), .SEL_PC_UPDATER(a_upd), .SEL_MUX(a_mux),
        .instr_valid(a_valid), .busy(a_busy), .halted(a_halted), .issue_count(a_cnt)
    );

    fetch_sequencer #(.MEM_LATENCY(3), .CNT_WIDTH(16)) dut3 (
        .clk(clk), .reset(reset), .start(start), .dec_has_arg(dec_has_arg),
        .dec_is_jump(dec_is_jump), .exec_ready(exec_ready), .branch_req(branch_req),
        .branch_type(branch_type), .halt_req(halt_req),
        .CTRL_REG_INSTR(b_instr), .CTRL_REG_ARG(b_arg), .CTRL_REG_JUMP(b_jump),
        .CTRL_REG_PC(b_pc), .SEL_PC_UPDATER(b_upd), .SEL_MUX(b_mux),
        .instr_valid(b_valid), .busy(b_busy), .halted(b_halted), .issue_count(b_cnt)
    );

    // {INSTR, ARG, JUMP, PC, UPD, MUX[1:0], valid, busy, halted}
    wire [9:0] sa = {a_instr, a_arg, a_jump, a_pc, a_upd, a_mux, a_valid, a_busy, a_halted};
    wire [9:0] sb = {b_instr, b_arg, b_jump, b_pc, b_upd, b_mux, b_valid, b_busy, b_halted};

    localparam logic [9:0] E_IDLE = 10'b0000_0_00_0_0_0;
    localparam logic [9:0] E_WAIT = 10'b0000_0_00_0_1_0;
    localparam logic [9:0] E_INS  = 10'b1001_0_00_0_1_0;
    localparam logic [9:0] E_ARG  = 10'b0101_0_00_0_1_0;
    localparam logic [9:0] E_EXT  = 10'b0011_1_00_0_1_0;
    localparam logic [9:0] E_ISS  = 10'b0000_0_00_1_1_0;
    localparam logic [9:0] E_REL  = 10'b0001_0_10_1_1_0;
    localparam logic [9:0] E_HLT  = 10'b0000_0_00_0_0_1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0; dec_has_arg = 1'b0; dec_is_jump = 1'b0;
        exec_ready = 1'b0; branch_req = 1'b0; branch_type = 2'b00; halt_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [9:0] seq2 [7];
    logic [9:0] seq5 [14];

    initial begin
        // reset state
        #2;
        chk("rst_sig", 32'(sa), 32'(E_IDLE));
        chk("rst_cnt", 32'(a_cnt), 0);
        chk("rst_sig3", 32'(sb), 32'(E_IDLE));
        @(negedge clk);
        reset = 1'b1;

        // plain instructions, no argument: 4-cycle period
        start = 1'b1; exec_ready = 1'b1;
        tick(); start = 1'b0;
        chk("t1_wi", 32'(sa), 32'(E_WAIT));
        tick(); chk("t1_ins", 32'(sa), 32'(E_INS));
        tick(); chk("t1_wa", 32'(sa), 32'(E_WAIT));
        tick(); chk("t1_iss", 32'(sa), 32'(E_ISS));
        tick(); chk("t1_wi2", 32'(sa), 32'(E_WAIT));
        chk("t1_cnt", 32'(a_cnt), 1);
        tick(); chk("t1_ins2", 32'(sa), 32'(E_INS));
        tick(); tick(); chk("t1_iss2", 32'(sa), 32'(E_ISS));

        // argument + extension word
        do_reset();
        start = 1'b1; dec_has_arg = 1'b1; dec_is_jump = 1'b1; exec_ready = 1'b1;
        seq2 = '{E_WAIT, E_INS, E_WAIT, E_ARG, E_WAIT, E_EXT, E_ISS};
        for (int i = 0; i < 7; i++) begin
            tick(); start = 1'b0;
            chk($sformatf("t2_c%0d", i + 1), 32'(sa), 32'(seq2[i]));
        end

        // stalled issue, then relative branch
        do_reset();
        start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("t3_iss", 32'(sa), 32'(E_ISS));
        branch_req = 1'b1; branch_type = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_stall", 32'(sa), 32'(E_ISS));
        end
        chk("t3_cnt0", 32'(a_cnt), 0);
        exec_ready = 1'b1; #1;
        chk("t3_rel", 32'(sa), 32'(E_REL));
        tick(); branch_req = 1'b0; branch_type = 2'b00;
        chk("t3_wi", 32'(sa), 32'(E_WAIT));
        chk("t3_cnt1", 32'(a_cnt), 1);

        // halt beats branch; start ignored afterwards
        tick(); tick(); tick();
        halt_req = 1'b1; branch_req = 1'b1; branch_type = 2'b11; #1;
        chk("t4_iss", 32'(sa), 32'(E_ISS));
        tick(); halt_req = 1'b0; branch_req = 1'b0; branch_type = 2'b00;
        chk("t4_hlt", 32'(sa), 32'(E_HLT));
        chk("t4_cnt", 32'(a_cnt), 2);
        start = 1'b1;
        tick(); tick(); start = 1'b0;
        chk("t4_hold", 32'(sa), 32'(E_HLT));

        // MEM_LATENCY=3, then async reset during WAIT_A
        do_reset();
        start = 1'b1; dec_has_arg = 1'b1; exec_ready = 1'b1;
        seq5 = '{E_WAIT, E_WAIT, E_WAIT, E_INS, E_WAIT, E_WAIT, E_WAIT, E_ARG, E_ISS,
                 E_WAIT, E_WAIT, E_WAIT, E_INS, E_WAIT};
        for (int i = 0; i < 14; i++) begin
            tick(); start = 1'b0;
            chk($sformatf("t5_c%0d", i + 1), 32'(sb), 32'(seq5[i]));
        end
        chk("t5_cnt", 32'(b_cnt), 1);
        reset = 1'b0; #1;
        chk("t5_rst_sig", 32'(sb), 32'(E_IDLE));
        chk("t5_rst_cnt", 32'(b_cnt), 0);
        @(negedge clk); reset = 1'b1;

        // counter wrap with branch_type 00
        do_reset();
        start = 1'b1; exec_ready = 1'b1; branch_req = 1'b1; branch_type = 2'b00;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        chk("t6_seq", 32'(sa), 32'(E_ISS));
        repeat (69) tick();
        chk("t6_wrap", 32'(a_cnt), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
